// File: rtl/sram_read_return_router.sv
// Steers SRAM read returns to the r0/r1 data FIFOs using an in-order owner tag queue,
// and throttles per-port issue so no in-flight read can overflow its destination FIFO.
module sram_read_return_router_port #(
  parameter int PORT_MAX = 4,
  parameter int DW       = 32
) (
  input  logic          sram_clock,
  input  logic          reset,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          prog_full_i,
  input  logic          tag_full_i,
  input  logic [DW-1:0] wdata_i,
  output logic          issue_ok_o,
  output logic          wr_en_o,
  output logic [DW-1:0] wr_data_o
);
  localparam int CW = $clog2(PORT_MAX + 1);
  localparam logic [CW-1:0] PMAX = CW'(PORT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_q;
  logic [DW-1:0] wr_data_q, wr_data_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i) cnt_d = cnt_q - 1'b1;
    wr_data_d = dec_i ? wdata_i : wr_data_q;
  end

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_en_q   <= dec_i;
      wr_data_q <= wr_data_d;
    end
  end

  assign issue_ok_o = !prog_full_i && (cnt_q < PMAX) && !tag_full_i;
  assign wr_en_o    = wr_en_q;
  assign wr_data_o  = wr_data_q;
endmodule

module sram_read_return_router #(
  parameter int TAG_DEPTH = 8,
  parameter int PORT_MAX  = 4,
  parameter int DW        = 32
) (
  input  logic          sram_clock,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic          issue_port,
  input  logic          sram_data_out_valid,
  input  logic [DW-1:0] sram_data_out,
  input  logic          r0_prog_full,
  input  logic          r1_prog_full,
  output logic          r0_issue_ok,
  output logic          r1_issue_ok,
  output logic          r0_wr_en,
  output logic [DW-1:0] r0_wr_data,
  output logic          r1_wr_en,
  output logic [DW-1:0] r1_wr_data,
  output logic          err_overflow,
  output logic          err_underflow
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_DEPTH-1:0] tag_q;
  logic                 err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic                 tag_full, tag_empty, push, pop, head;
  logic [1:0]           inc, dec, pf, issue_ok, wr_en;
  logic [1:0][DW-1:0]   wr_data;

  // wrap bit differs with equal index => full
  assign tag_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tag_empty = (wr_ptr_q == rd_ptr_q);
  assign push      = issue_valid && !tag_full;
  assign pop       = sram_data_out_valid && !tag_empty;
  assign head      = tag_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    err_ovf_d = err_ovf_q | (issue_valid && tag_full);
    err_unf_d = err_unf_q | (sram_data_out_valid && tag_empty);
    inc       = {push && issue_port, push && !issue_port};
    dec       = {pop && head, pop && !head};
    pf        = {r1_prog_full, r0_prog_full};
  end

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // tag storage is only read when non-empty, so it needs no reset
  always_ff @(posedge sram_clock) begin
    if (push) tag_q[wr_ptr_q[AW-1:0]] <= issue_port;
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    sram_read_return_router_port #(.PORT_MAX(PORT_MAX), .DW(DW)) u_port (
      .sram_clock (sram_clock),
      .reset      (reset),
      .inc_i      (inc[g]),
      .dec_i      (dec[g]),
      .prog_full_i(pf[g]),
      .tag_full_i (tag_full),
      .wdata_i    (sram_data_out),
      .issue_ok_o (issue_ok[g]),
      .wr_en_o    (wr_en[g]),
      .wr_data_o  (wr_data[g])
    );
  end

  assign r0_issue_ok   = issue_ok[0];
  assign r1_issue_ok   = issue_ok[1];
  assign r0_wr_en      = wr_en[0];
  assign r1_wr_en      = wr_en[1];
  assign r0_wr_data    = wr_data[0];
  assign r1_wr_data    = wr_data[1];
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
endmodule
